trailing_zeroes_decoder: RTL and testbench
==========================================

TRAILING_ZEROES_DECODER -- requirements
Module: trailing_zeroes_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: width of the reconstructed word, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port din, input, $clog2(DATA_WIDTH)+1 bits: trailing-zero count to expand.
REQ-005 SHALL have port din_valid, input, 1 bit: din holds a valid count.
REQ-006 SHALL have port din_ready, output, 1 bit: block accepts din this cycle.
REQ-007 SHALL have port dout_bit, output, 1 bit: serial reconstructed bit, LSB first.
REQ-008 SHALL have port dout_valid, output, 1 bit: dout_bit is valid.
REQ-009 SHALL have port dout_ready, input, 1 bit: downstream accepts dout_bit.
REQ-010 SHALL have port dout_last, output, 1 bit: current beat is bit DATA_WIDTH-1 of the word.
REQ-011 SHALL have port word, output, DATA_WIDTH bits: parallel reconstructed word.
REQ-012 SHALL have port word_valid, output, 1 bit: one-cycle pulse, word just completed.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse, accepted count was out of range.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-015 SHALL drive din_ready=1 only in IDLE; input handshake = din_valid & din_ready.
REQ-016 SHALL, on an input handshake, register count=din, clear the bit index to 0, and enter SHIFT next cycle.
REQ-017 SHALL, when accepted din > DATA_WIDTH, clamp the registered count to DATA_WIDTH and pulse err for exactly the cycle after the handshake.
REQ-018 SHALL hold dout_valid=1 throughout SHIFT and 0 in IDLE.
REQ-019 SHALL drive dout_bit = (index == count) in SHIFT, and 0 in IDLE.
REQ-020 SHALL drive dout_last = (index == DATA_WIDTH-1) in SHIFT, and 0 in IDLE.
REQ-021 SHALL advance the index by 1 only on an output handshake (dout_valid & dout_ready).
REQ-022 SHALL hold dout_bit, dout_last and the index stable while dout_ready=0; stall length is unbounded.
REQ-023 SHALL, on the output handshake with dout_last=1, return to IDLE and load word in the same edge.
REQ-024 SHALL pulse word_valid for exactly the cycle after that last handshake.
REQ-025 SHALL load word with exactly bit[count] set and all other bits 0 when count < DATA_WIDTH.
REQ-026 SHALL load word with all zeros when count == DATA_WIDTH.
REQ-027 SHALL emit exactly DATA_WIDTH beats per accepted count.
REQ-028 SHALL keep word unchanged between completions.
REQ-029 SHALL ignore din and din_valid in SHIFT, with no effect on state.
REQ-030 SHALL sustain a minimum period of DATA_WIDTH+1 cycles per word with dout_ready held at 1.
REQ-031 SHALL, as the inverse of the trailing-zero counter, produce a word that yields trailing-zero count == accepted count (after clamping) when fed back into that counter.

Reset
REQ-032 SHALL, on resetn low, immediately and asynchronously force FSM=IDLE, index=0, count=0, word=0, and word_valid=0, err=0, dout_valid=0, dout_bit=0, dout_last=0.
REQ-033 SHALL discard any partially emitted word when reset is asserted mid-SHIFT, with no word_valid pulse.
REQ-034 SHALL have din_ready=1 in the first cycle after resetn deasserts.

Verification (DATA_WIDTH=4)
REQ-035 SHALL verify the basic expansion: din=2 accepted, dout_ready=1 -> beats 0,0,1,0, dout_last on the 4th beat, then word_valid pulse with word=4'b0100.
REQ-036 SHALL verify the all-zero case: din=4 -> beats 0,0,0,0, word=4'b0000, err stays 0.
REQ-037 SHALL verify clamping: din=7 -> err pulse for one cycle, beats 0,0,0,0, word=4'b0000.
REQ-038 SHALL verify back-pressure: din=0 with dout_ready low for 3 cycles at beat 0 -> dout_bit held at 1, index not advanced, total 4 beats 1,0,0,0, word=4'b0001.
REQ-039 SHALL verify input blocking and throughput: din_valid held high with counts 1 then 3 -> second count accepted only after returning to IDLE, words 4'b0010 then 4'b1000, 5-cycle period.
REQ-040 SHALL verify mid-operation reset: resetn low at beat 2 of din=3 -> all outputs 0 immediately, no word_valid, din_ready=1 after release.

Source files
------------

// File: rtl/trailing_zeroes_decoder.sv
// rtl/trailing_zeroes_decoder.sv - expands a trailing-zero count back into a one-hot word, serial LSB first
`timescale 1ns/1ps

module trailing_zeroes_decoder #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [$clog2(DATA_WIDTH):0]   din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          dout_bit,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last,
  output logic [DATA_WIDTH-1:0]         word,
  output logic                          word_valid,
  output logic                          err
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] C_MAX  = CW'(DATA_WIDTH);
  localparam logic [IW-1:0] C_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_count;
  logic [IW-1:0]         r_index;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_word_valid;
  logic                  r_err;

  logic                  w_in_hs;
  logic                  w_out_hs;
  logic                  w_is_last;
  logic                  w_bit;
  logic                  w_over;
  logic [DATA_WIDTH-1:0] w_word_next;

  assign w_in_hs   = din_valid && (r_state == S_IDLE);
  assign w_out_hs  = (r_state == S_SHIFT) && dout_ready;
  assign w_is_last = (r_index == C_LAST);
  assign w_bit     = ({1'b0, r_index} == r_count);
  assign w_over    = (din > C_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (din_valid) begin
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (dout_ready && w_is_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // A clamped count of DATA_WIDTH matches no bit position, so the word comes out all zero.
  always_comb begin
    w_word_next = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_word_next[i] = (r_count == CW'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count      <= '0;
      r_index      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      r_err        <= 1'b0;
      if (w_in_hs) begin
        r_count <= w_over ? C_MAX : din;
        r_index <= '0;
        r_err   <= w_over;
      end
      if (w_out_hs) begin
        if (w_is_last) begin
          r_word       <= w_word_next;
          r_word_valid <= 1'b1;
          r_index      <= '0;
        end else begin
          r_index <= r_index + 1'b1;
        end
      end
    end
  end

  // Stream outputs derive from the state register so reset clears them without waiting for a clock.
  assign din_ready  = (r_state == S_IDLE);
  assign dout_valid = (r_state == S_SHIFT);
  assign dout_bit   = dout_valid && w_bit;
  assign dout_last  = dout_valid && w_is_last;
  assign word       = r_word;
  assign word_valid = r_word_valid;
  assign err        = r_err;

endmodule

// File: tb/tb_trailing_zeroes_decoder.sv
// tb/tb_trailing_zeroes_decoder.sv - scoreboard bench for trailing_zeroes_decoder at DATA_WIDTH=4
`timescale 1ns/1ps

module tb_trailing_zeroes_decoder;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       dout_bit;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_last;
  logic [3:0] word;
  logic       word_valid;
  logic       err;

  typedef struct packed {
    logic b;
    logic l;
  } beat_t;

  beat_t      beat_q[$];
  logic [3:0] word_q[$];
  int         word_cyc[$];
  int         errors   = 0;
  int         checks   = 0;
  int         cyc      = 0;
  int         err_seen = 0;
  int         err_exp  = 0;

  trailing_zeroes_decoder #(.DATA_WIDTH(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout_bit   (dout_bit),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .word       (word),
    .word_valid (word_valid),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      beat_q.push_back('{b: w[i], l: (i == 3)});
    end
    word_q.push_back(w);
  endtask

  // Monitor: pops expected beats on output handshakes and expected words on word_valid.
  always @(negedge clk) begin
    if (resetn) begin
      if (dout_valid) begin
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else if (dout_ready) begin
          beat_t e;
          e = beat_q.pop_front();
          chk("beat_bit", dout_bit, e.b);
          chk("beat_last", dout_last, e.l);
        end else begin
          chk("stall_bit", dout_bit, beat_q[0].b);
          chk("stall_last", dout_last, beat_q[0].l);
        end
      end
      if (word_valid) begin
        word_cyc.push_back(cyc);
        if (word_q.size() == 0) chk("word_unexpected", 1, 0);
        else chk("word", word, word_q.pop_front());
      end
      if (err) err_seen++;
    end
  end

  task automatic send(input logic [2:0] c, input logic [3:0] w, input logic e);
    int n = 0;
    @(posedge clk); #1;
    din = c;
    din_valid = 1'b1;
    while (!din_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
    push_word(w);
    err_exp += int'(e);
    @(posedge clk); #1;
    din_valid = 1'b0;
    din = 3'd5;
    chk("err_after_accept", err, e);
    chk("ready_in_shift", din_ready, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((beat_q.size() != 0 || word_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn     = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    #3;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_bit", dout_bit, 0);
    chk("rst_dout_last", dout_last, 0);
    chk("rst_word", word, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", din_ready, 1);

    // Basic expansion, all-zero, clamping.
    send(3'd2, 4'b0100, 1'b0);
    wait_done();
    send(3'd4, 4'b0000, 1'b0);
    wait_done();
    send(3'd7, 4'b0000, 1'b1);
    wait_done();

    // Back-pressure at beat 0.
    dout_ready = 1'b0;
    send(3'd0, 4'b0001, 1'b0);
    repeat (3) @(posedge clk);
    #1 dout_ready = 1'b1;
    wait_done();

    // din_valid held high: second count waits for IDLE; din changes in SHIFT are ignored.
    begin
      int n = 0;
      @(posedge clk); #1;
      din = 3'd1;
      din_valid = 1'b1;
      push_word(4'b0010);
      @(posedge clk); #1;
      din = 3'd3;
      push_word(4'b1000);
      chk("block_ready", din_ready, 0);
      while (!din_ready && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 100) chk("tput_timeout", 0, 1);
      @(posedge clk); #1;
      din_valid = 1'b0;
      wait_done();
      if (word_cyc.size() >= 2)
        chk("word_period", word_cyc[word_cyc.size()-1] - word_cyc[word_cyc.size()-2], 5);
      else
        chk("word_period_count", word_cyc.size(), 2);
    end

    // Reset asserted while beat 2 of count 3 is presented.
    send(3'd3, 4'b1000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_dout_valid", dout_valid, 0);
    chk("mid_rst_dout_bit", dout_bit, 0);
    chk("mid_rst_dout_last", dout_last, 0);
    chk("mid_rst_word", word, 0);
    chk("mid_rst_word_valid", word_valid, 0);
    chk("mid_rst_err", err, 0);
    beat_q.delete();
    word_q.delete();
    @(posedge clk); #1;
    chk("in_rst_word_valid", word_valid, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", din_ready, 1);
    chk("mid_rst_idle", dout_valid, 0);
    repeat (6) @(negedge clk);

    chk("beats_left", beat_q.size(), 0);
    chk("words_left", word_q.size(), 0);
    chk("err_pulses", err_seen, err_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
